// File: rtl/amount_display_pkg.sv
// Shared types and constants for the amount display decoder: FSM state
// encoding, active-low seven-segment codes and a small constant helper.
package amount_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low segment patterns for digits 0..9 (entry 0 is the last element).
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // 10^n, used to find the largest amount the display can show.
    function automatic int pow10(input int n);
        int result;
        result = 1;
        for (int i = 0; i < n; i++) begin
            result = result * 10;
        end
        return result;
    endfunction

endpackage

// File: rtl/amount_display_seven_segment_encoder.sv
// Combinational BCD digit to active-low seven-segment encoder.
// Codes above 9 cannot come out of a valid conversion and are shown blank.
module seven_segment_encoder
    import amount_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup, with anything outside 0..9 blanked.
    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/amount_display.sv
// amount_display: converts the dispenser's binary amount into decimal digits
// for active-low seven-segment displays using an iterative double-dabble
// conversion, and updates every digit in a single edge once it is finished.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros.
module amount_display
    import amount_display_pkg::*;
#(
    parameter int DIGIT_COUNT  = 4,
    parameter int AMOUNT_WIDTH = 14
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [31:0]         total_amount_in_ml,
    output logic [7*DIGIT_COUNT-1:0]   hex,
    output logic                       busy,
    output logic                       update_done
);

    localparam int BCD_WIDTH = 4 * DIGIT_COUNT;
    localparam int CNT_WIDTH = $clog2(AMOUNT_WIDTH + 1);
    localparam int signed MAX_VALUE = pow10(DIGIT_COUNT) - 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(AMOUNT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1);

    state_t                          state;
    logic signed [31:0]              captured;
    logic                            stale;
    logic                            ovf;
    logic [CNT_WIDTH-1:0]            shift_cnt;
    logic [BCD_WIDTH-1:0]            bcd;
    logic [BCD_WIDTH-1:0]            bcd_adj;
    logic [AMOUNT_WIDTH-1:0]         bin;
    logic [BCD_WIDTH+AMOUNT_WIDTH-1:0] shifted;
    logic [7*DIGIT_COUNT-1:0]        digit_seg;
    logic [7*DIGIT_COUNT-1:0]        next_hex;
    logic                            start;
    logic                            out_of_range;
`ifdef LEADING_ZERO_BLANK_EN
    logic                            leading;
`endif

    // A new conversion is needed when the amount moved or after a reset.
    always_comb begin
        start        = (total_amount_in_ml != captured) || stale;
        out_of_range = (total_amount_in_ml < 0) || (total_amount_in_ml > MAX_VALUE);
    end

    // Add-3 correction on every BCD nibble that would overflow past 9 when doubled.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGIT_COUNT; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin} << 1;
    end

    genvar g;
    generate
        for (g = 0; g < DIGIT_COUNT; g++) begin : gen_digit
            seven_segment_encoder u_encoder (
                .digit (bcd[4*g +: 4]),
                .seg   (digit_seg[7*g +: 7])
            );
        end
    endgenerate

    // Final display image: optional leading-zero blanking, dashes on overflow.
    always_comb begin
        next_hex = digit_seg;
`ifdef LEADING_ZERO_BLANK_EN
        leading = 1'b1;
        for (int i = DIGIT_COUNT - 1; i >= 1; i--) begin
            if (leading && (bcd[4*i +: 4] == 4'd0)) begin
                next_hex[7*i +: 7] = SEG_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
`endif
        if (ovf) begin
            next_hex = {DIGIT_COUNT{SEG_DASH}};
        end
    end

    // Capture / shift / commit sequencer with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            captured    <= '0;
            stale       <= 1'b1;
            ovf         <= 1'b0;
            shift_cnt   <= '0;
            bcd         <= '0;
            bin         <= '0;
            hex         <= {DIGIT_COUNT{SEG_BLANK}};
            busy        <= 1'b0;
            update_done <= 1'b0;
        end else begin
            update_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        captured  <= total_amount_in_ml;
                        stale     <= 1'b0;
                        ovf       <= out_of_range;
                        bcd       <= '0;
                        bin       <= total_amount_in_ml[AMOUNT_WIDTH-1:0];
                        shift_cnt <= CNT_LOAD;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd       <= shifted[BCD_WIDTH+AMOUNT_WIDTH-1:AMOUNT_WIDTH];
                    bin       <= shifted[AMOUNT_WIDTH-1:0];
                    shift_cnt <= shift_cnt - 1'b1;
                    if (shift_cnt == CNT_LAST) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    hex         <= next_hex;
                    update_done <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amount_display.sv
// Directed testbench for amount_display: reset, conversions, overflow,
// mid-conversion input change and asynchronous reset during a conversion.
// Expected digits follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_amount_display;

    localparam logic [27:0] HEX_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
    localparam logic [27:0] HEX_DASH  = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [27:0] HEX_1380  = {7'h79, 7'h30, 7'h00, 7'h40};
    localparam logic [27:0] HEX_9999  = {7'h10, 7'h10, 7'h10, 7'h10};
    localparam logic [27:0] HEX_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [27:0] HEX_0     = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] HEX_640   = {7'h7F, 7'h02, 7'h19, 7'h40};
    localparam logic [27:0] HEX_56    = {7'h7F, 7'h7F, 7'h12, 7'h02};
`else
    localparam logic [27:0] HEX_0     = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] HEX_640   = {7'h40, 7'h02, 7'h19, 7'h40};
    localparam logic [27:0] HEX_56    = {7'h40, 7'h40, 7'h12, 7'h02};
`endif

    logic               clock;
    logic               reset;
    logic signed [31:0] total_amount_in_ml;
    logic [27:0]        hex;
    logic               busy;
    logic               update_done;

    int checks   = 0;
    int failures = 0;

    amount_display dut (
        .clock              (clock),
        .reset              (reset),
        .total_amount_in_ml (total_amount_in_ml),
        .hex                (hex),
        .busy               (busy),
        .update_done        (update_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Watch 40 cycles, recording first-pulse latency, pulse count and busy cycles.
    task automatic wait_commit(output int latency, output int pulses, output int busy_cycles);
        latency     = 0;
        pulses      = 0;
        busy_cycles = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (busy) busy_cycles++;
            if (update_done) begin
                pulses++;
                if (latency == 0) latency = n;
            end
        end
    endtask

    task automatic apply_stimulus(input int value, output int latency, output int pulses,
                                  output int busy_cycles);
        @(posedge clock);
        #1;
        total_amount_in_ml = value;
        wait_commit(latency, pulses, busy_cycles);
    endtask

    initial begin
        int latency;
        int pulses;
        int busy_cycles;
        int mixed;
        logic [27:0] first_commit;
        logic [27:0] second_commit;

        reset              = 1'b0;
        total_amount_in_ml = 0;
        repeat (3) @(posedge clock);
        #1;
        check_output("reset_hex", 64'(hex), 64'(HEX_BLANK));
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_update_done", 64'(update_done), 64'd0);

        reset = 1'b1;
        wait_commit(latency, pulses, busy_cycles);
        check_output("zero_latency", 64'(latency), 64'd16);
        check_output("zero_pulses", 64'(pulses), 64'd1);
        check_output("zero_hex", 64'(hex), 64'(HEX_0));

        apply_stimulus(640, latency, pulses, busy_cycles);
        check_output("v640_latency", 64'(latency), 64'd16);
        check_output("v640_pulses", 64'(pulses), 64'd1);
        check_output("v640_busy_cycles", 64'(busy_cycles), 64'd15);
        check_output("v640_hex", 64'(hex), 64'(HEX_640));

        apply_stimulus(1380, latency, pulses, busy_cycles);
        check_output("v1380_pulses", 64'(pulses), 64'd1);
        check_output("v1380_hex", 64'(hex), 64'(HEX_1380));

        apply_stimulus(10000, latency, pulses, busy_cycles);
        check_output("v10000_pulses", 64'(pulses), 64'd1);
        check_output("v10000_hex", 64'(hex), 64'(HEX_DASH));

        apply_stimulus(-1, latency, pulses, busy_cycles);
        check_output("neg1_pulses", 64'(pulses), 64'd1);
        check_output("neg1_hex", 64'(hex), 64'(HEX_DASH));

        apply_stimulus(9999, latency, pulses, busy_cycles);
        check_output("v9999_pulses", 64'(pulses), 64'd1);
        check_output("v9999_busy_cycles", 64'(busy_cycles), 64'd15);
        check_output("v9999_hex", 64'(hex), 64'(HEX_9999));

        // 1234 applied, then changed to 56 after five shifts have happened.
        @(posedge clock);
        #1;
        total_amount_in_ml = 1234;
        pulses        = 0;
        mixed         = 0;
        first_commit  = '0;
        second_commit = '0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            #1;
            if (n == 6) total_amount_in_ml = 56;
            if (update_done) begin
                pulses++;
                if (pulses == 1) first_commit = hex;
                else second_commit = hex;
            end
            if (hex !== HEX_9999 && hex !== HEX_1234 && hex !== HEX_56) mixed++;
        end
        check_output("change_pulses", 64'(pulses), 64'd2);
        check_output("change_first_hex", 64'(first_commit), 64'(HEX_1234));
        check_output("change_second_hex", 64'(second_commit), 64'(HEX_56));
        check_output("change_mixed_cycles", 64'(mixed), 64'd0);

        // Asynchronous reset at shift cycle 7 of a 640 conversion.
        @(posedge clock);
        #1;
        total_amount_in_ml = 640;
        repeat (8) @(posedge clock);
        #1;
        check_output("midreset_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check_output("midreset_hex", 64'(hex), 64'(HEX_BLANK));
        check_output("midreset_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        wait_commit(latency, pulses, busy_cycles);
        check_output("release_latency", 64'(latency), 64'd16);
        check_output("release_pulses", 64'(pulses), 64'd1);
        check_output("release_hex", 64'(hex), 64'(HEX_640));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
